// File: rtl/burst_fetch_pkg.sv
// Shared types and width helpers for the burst fetch FIFO slice.
package burst_fetch_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RECV = 2'd2
   } fetch_state_t;

   // Pointer width for a power-of-two depth; a 1-entry pointer still needs one bit.
   function automatic int unsigned ptr_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Occupancy width: must be able to represent DEPTH itself.
   function automatic int unsigned cnt_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

   // Beat counter width: must be able to represent BURST itself.
   function automatic int unsigned beat_width(input int unsigned burst);
      return (burst > 1) ? $clog2(burst + 1) : 1;
   endfunction

endpackage

// File: rtl/sync_fifo_core.sv
// Synchronous FIFO: storage, pointers, registered occupancy and flags, registered pop data.
module sync_fifo_core
   import burst_fetch_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wr_en,
   input  logic [DATA_W-1:0]       wr_data,
   input  logic                    rd_en,
   output logic [DATA_W-1:0]       rd_data,
   output logic                    rd_valid,
   output logic                    empty,
   output logic                    full,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int unsigned PTR_W = ptr_width(DEPTH);
   localparam int unsigned CNT_W = cnt_width(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count_n;
   logic              push;
   logic              pop;

   // Accepted operations and next occupancy.
   always_comb begin
      push    = wr_en;
      pop     = rd_en && !empty;
      count_n = count;
      if (push && !pop) begin
         count_n = count + CNT_W'(1);
      end else if (pop && !push) begin
         count_n = count - CNT_W'(1);
      end
   end

   // Storage array; contents need no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointers wrap modulo DEPTH; flags are registered alongside count.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         empty    <= 1'b1;
         full     <= 1'b0;
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr  <= rd_ptr + PTR_W'(1);
            rd_data <= mem[rd_ptr];
         end
         rd_valid <= pop;
         count    <= count_n;
         empty    <= (count_n == CNT_W'(0));
         full     <= (count_n == CNT_W'(DEPTH));
      end
   end

   // Space is reserved before each burst, so a write into a full FIFO is a design error.
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(wr_en && full));
      end
   end

endmodule

// File: rtl/burst_fetch_fifo.sv
// Fetches a fixed-length burst per accepted request pulse and buffers it for a reader.
module burst_fetch_fifo
   import burst_fetch_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned BURST  = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_pulse,
   output logic                    src_req,
   input  logic                    src_ack,
   input  logic                    src_valid,
   input  logic [DATA_W-1:0]       src_data,
   input  logic                    rd_en,
   output logic [DATA_W-1:0]       rd_data,
   output logic                    rd_valid,
   output logic                    empty,
   output logic                    full,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    busy,
   output logic                    req_drop,
   output logic                    proto_err
);

   localparam int unsigned CNT_W  = cnt_width(DEPTH);
   localparam int unsigned BEAT_W = beat_width(BURST);

   fetch_state_t      state;
   fetch_state_t      state_n;
   logic [BEAT_W-1:0] beat;
   logic [BEAT_W-1:0] beat_n;
   logic              src_req_n;
   logic              busy_n;
   logic              req_drop_n;
   logic              proto_err_n;
   logic              fifo_wr;
   logic              space_ok;

   // Next-state, beat counting, space check and error pulses.
   always_comb begin
      state_n     = state;
      beat_n      = beat;
      src_req_n   = 1'b0;
      req_drop_n  = 1'b0;
      proto_err_n = 1'b0;
      fifo_wr     = 1'b0;
      space_ok    = (CNT_W'(DEPTH) - count) >= CNT_W'(BURST);
      unique case (state)
         IDLE: begin
            proto_err_n = src_valid;
            if (req_pulse) begin
               if (space_ok) begin
                  state_n   = REQ;
                  src_req_n = 1'b1;
               end else begin
                  req_drop_n = 1'b1;
               end
            end
         end
         REQ: begin
            proto_err_n = src_valid;
            req_drop_n  = req_pulse;
            if (src_ack) begin
               state_n = RECV;
               beat_n  = '0;
            end else begin
               src_req_n = 1'b1;
            end
         end
         RECV: begin
            req_drop_n = req_pulse;
            if (src_valid) begin
               fifo_wr = 1'b1;
               beat_n  = beat + BEAT_W'(1);
               if (beat_n == BEAT_W'(BURST)) begin
                  state_n = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
      busy_n = (state_n != IDLE);
   end

   // State and registered control outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         beat      <= '0;
         src_req   <= 1'b0;
         busy      <= 1'b0;
         req_drop  <= 1'b0;
         proto_err <= 1'b0;
      end else begin
         state     <= state_n;
         beat      <= beat_n;
         src_req   <= src_req_n;
         busy      <= busy_n;
         req_drop  <= req_drop_n;
         proto_err <= proto_err_n;
      end
   end

   sync_fifo_core #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (fifo_wr),
      .wr_data  (src_data),
      .rd_en    (rd_en),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .empty    (empty),
      .full     (full),
      .count    (count)
   );

endmodule

// File: tb/tb_burst_fetch_fifo.sv
// Bench for burst_fetch_fifo: directed sequence with random data, checked against a queue model.
module tb_burst_fetch_fifo;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned DEPTH  = 16;
   localparam int unsigned BURST  = 4;
   localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              req_pulse = 1'b0;
   logic              src_ack = 1'b0;
   logic              src_valid = 1'b0;
   logic [DATA_W-1:0] src_data = '0;
   logic              rd_en = 1'b0;
   logic              src_req;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              empty;
   logic              full;
   logic [CNT_W-1:0]  count;
   logic              busy;
   logic              req_drop;
   logic              proto_err;

   int vectors     = 0;
   int miscompares = 0;

   // Transaction-level model: buffered words, an outstanding request, beats still owed.
   logic [DATA_W-1:0] mq [$];
   bit                m_wait = 1'b0;
   int                m_left = 0;
   bit                e_drop = 1'b0;
   bit                e_perr = 1'b0;
   bit                e_rdv  = 1'b0;
   logic [DATA_W-1:0] e_rdd  = '0;
   int                m_accepted = 0;

   always #5 clk = ~clk;

   burst_fetch_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .BURST  (BURST)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_pulse (req_pulse),
      .src_req   (src_req),
      .src_ack   (src_ack),
      .src_valid (src_valid),
      .src_data  (src_data),
      .rd_en     (rd_en),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .empty     (empty),
      .full      (full),
      .count     (count),
      .busy      (busy),
      .req_drop  (req_drop),
      .proto_err (proto_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      bit idle;
      bit was_wait;
      int sz;
      if (rst) begin
         mq.delete();
         m_wait = 1'b0;
         m_left = 0;
         e_drop = 1'b0;
         e_perr = 1'b0;
         e_rdv  = 1'b0;
      end else begin
         sz       = mq.size();
         was_wait = m_wait;
         idle     = !m_wait && (m_left == 0);
         e_drop   = 1'b0;
         e_perr   = 1'b0;
         e_rdv    = 1'b0;
         if (rd_en && sz > 0) begin
            e_rdd = mq.pop_front();
            e_rdv = 1'b1;
         end
         if (req_pulse) begin
            if (idle && (int'(DEPTH) - sz >= int'(BURST))) begin
               m_wait = 1'b1;
               m_accepted++;
            end else begin
               e_drop = 1'b1;
            end
         end
         if (src_valid) begin
            if (m_left > 0) begin
               mq.push_back(src_data);
               m_left--;
            end else begin
               e_perr = 1'b1;
            end
         end
         if (was_wait && src_ack) begin
            m_wait = 1'b0;
            m_left = BURST;
         end
      end
   endtask

   // One clock: model update at the edge, compare #1 later, then release single-cycle inputs.
   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
      chk("src_req",   32'(src_req),   32'(m_wait));
      chk("busy",      32'(busy),      32'(m_wait || m_left > 0));
      chk("req_drop",  32'(req_drop),  32'(e_drop));
      chk("proto_err", 32'(proto_err), 32'(e_perr));
      chk("count",     32'(count),     32'(mq.size()));
      chk("empty",     32'(empty),     32'(mq.size() == 0));
      chk("full",      32'(full),      32'(mq.size() == DEPTH));
      chk("rd_valid",  32'(rd_valid),  32'(e_rdv));
      if (e_rdv) begin
         chk("rd_data", 32'(rd_data), 32'(e_rdd));
      end
      rst       = 1'b0;
      req_pulse = 1'b0;
      src_ack   = 1'b0;
      src_valid = 1'b0;
      rd_en     = 1'b0;
   endtask

   task automatic pop(input int n);
      repeat (n) begin
         rd_en = 1'b1;
         cyc();
      end
   endtask

   task automatic burst(input bit pop_rand);
      req_pulse = 1'b1;
      cyc();
      repeat ($urandom_range(2)) cyc();
      src_ack = 1'b1;
      cyc();
      for (int i = 0; i < int'(BURST); i++) begin
         if ($urandom_range(3) == 0) begin
            if (pop_rand) rd_en = 1'($urandom_range(1));
            cyc();
         end
         src_valid = 1'b1;
         src_data  = 8'($urandom);
         if (pop_rand) rd_en = 1'($urandom_range(1));
         cyc();
      end
   endtask

   initial begin
      bit fired;
      int pulses;
      int acc0;

      // Reset state
      rst = 1'b1;
      cyc();
      rst = 1'b1;
      cyc();

      // Basic burst with known data
      cyc();
      req_pulse = 1'b1;
      cyc();
      cyc();
      src_ack = 1'b1;
      cyc();
      for (int i = 0; i < int'(BURST); i++) begin
         src_valid = 1'b1;
         src_data  = 8'hA0 + 8'(i);
         cyc();
      end
      chk("basic_count", 32'(count), 32'd4);
      for (int i = 0; i < int'(BURST); i++) begin
         rd_en = 1'b1;
         cyc();
         chk("basic_rd_data", 32'(rd_data), 32'h0A0 + 32'(i));
      end
      chk("basic_empty", 32'(empty), 32'd1);

      // Space rejection: fill, free 3 words, request refused, free one more, request taken
      repeat (4) burst(1'b0);
      pop(3);
      req_pulse = 1'b1;
      cyc();
      cyc();
      chk("space_no_req", 32'(src_req), 32'd0);
      pop(1);
      burst(1'b0);
      pop(int'(DEPTH));
      rd_en = 1'b1;
      cyc();

      // Request while busy, plus data presented while idle
      req_pulse = 1'b1;
      cyc();
      src_ack = 1'b1;
      cyc();
      src_valid = 1'b1;
      src_data  = 8'($urandom);
      cyc();
      src_valid = 1'b1;
      src_data  = 8'($urandom);
      req_pulse = 1'b1;
      cyc();
      repeat (2) begin
         src_valid = 1'b1;
         src_data  = 8'($urandom);
         cyc();
      end
      src_valid = 1'b1;
      src_data  = 8'($urandom);
      cyc();
      cyc();
      pop(int'(BURST) + 1);

      // Six bursts with concurrent pops, crossing the pointer wrap
      for (int b = 0; b < 6; b++) begin
         burst(1'b1);
         pop(2);
      end
      pop(int'(DEPTH));

      // Reset mid-burst, then stray beats
      req_pulse = 1'b1;
      cyc();
      src_ack = 1'b1;
      cyc();
      repeat (2) begin
         src_valid = 1'b1;
         src_data  = 8'($urandom);
         cyc();
      end
      rst = 1'b1;
      cyc();
      repeat (2) begin
         src_valid = 1'b1;
         src_data  = 8'($urandom);
         cyc();
      end
      repeat (3) cyc();

      // Closed loop: one request per empty event, pops only once a burst has landed
      fired  = 1'b0;
      pulses = 0;
      acc0   = m_accepted;
      for (int c = 0; c < 300; c++) begin
         if (!empty) fired = 1'b0;
         if (empty && !fired) begin
            req_pulse = 1'b1;
            fired     = 1'b1;
            pulses++;
         end
         if (src_req) src_ack = 1'b1;
         if (m_left > 0 && $urandom_range(3) != 0) begin
            src_valid = 1'b1;
            src_data  = 8'($urandom);
         end
         if (!m_wait && m_left == 0 && !empty) rd_en = 1'($urandom_range(1));
         cyc();
      end
      chk("loop_bursts", 32'(m_accepted - acc0), 32'(pulses));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
